// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req{0,1}_valid_i / req{0,1}_ready_o request handshake (ready is combinational)
//   req{0,1}_a_i, _b_i, _s_i            operands and opcode of each requester
//   rsp{0,1}_valid_o / rsp{0,1}_ready_i response handshake, valid only toward the owner
//   rsp_o_o, rsp_zero_o, rsp_err_o      shared registered result, zero flag, illegal-opcode flag
//   alu_a_o, alu_b_o, alu_s_o           operands held stable at the ALU
//   alu_o_i, alu_zero_i                 ALU result and zero flag
//   busy_o                              high whenever an operation is in flight
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [2:0]       req0_s_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [2:0]       req1_s_i,
    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp_o_o,
    output logic             rsp_zero_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_s_o,
    input  logic [WIDTH-1:0] alu_o_i,
    input  logic             alu_zero_i,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_s_q, alu_s_d;
    logic [WIDTH-1:0] rsp_o_q, rsp_o_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic             grant0, grant1, accept, legal, rsp_hs;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [2:0]       sel_s;

    // On a tie the requester that was not served last wins
    assign grant0 = req0_valid_i && (!req1_valid_i || last_grant_q);
    assign grant1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
    assign accept = (state_q == IDLE) && (grant0 || grant1);
    assign sel_a  = grant1 ? req1_a_i : req0_a_i;
    assign sel_b  = grant1 ? req1_b_i : req0_b_i;
    assign sel_s  = grant1 ? req1_s_i : req0_s_i;
    assign legal  = sel_s inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    assign rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready_i : rsp0_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? (legal ? EXEC : RESP) : IDLE;
            EXEC:    state_d = (cnt_q == 4'd1) ? RESP : EXEC;
            RESP:    state_d = rsp_hs ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so every output reads 0 while reset is held
    always_comb begin
        req0_ready_o = rst_n && (state_q == IDLE) && grant0;
        req1_ready_o = rst_n && (state_q == IDLE) && grant1;
        rsp0_valid_o = (state_q == RESP) && !owner_q;
        rsp1_valid_o = (state_q == RESP) && owner_q;
        busy_o       = state_q != IDLE;
    end

    // An illegal opcode skips the ALU entirely and leaves alu_* untouched
    always_comb begin
        last_grant_d = rsp_hs ? owner_q : last_grant_q;
        owner_d      = accept ? grant1 : owner_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_s_d      = alu_s_q;
        rsp_o_d      = rsp_o_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        if (accept && legal) begin
            alu_a_d = sel_a;
            alu_b_d = sel_b;
            alu_s_d = sel_s;
            cnt_d   = 4'(ALU_LAT);
        end
        if (accept && !legal) begin
            rsp_o_d    = '0;
            rsp_zero_d = 1'b0;
            rsp_err_d  = 1'b1;
        end
        if (state_q == EXEC) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (state_q == EXEC && cnt_q == 4'd1) begin
            rsp_o_d    = alu_o_i;
            rsp_zero_d = alu_zero_i;
            rsp_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_s_q      <= '0;
            rsp_o_q      <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_s_q      <= alu_s_d;
            rsp_o_q      <= rsp_o_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_s_o    = alu_s_q;
    assign rsp_o_o    = rsp_o_q;
    assign rsp_zero_o = rsp_zero_q;
    assign rsp_err_o  = rsp_err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a cycle-level reference model for alu_share_arbiter
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         r0v, r0r, r1v, r1r, p0v, p0r, p1v, p1r, rz, re, az, bz;
    logic [W-1:0] r0a, r0b, r1a, r1b, ro, aa, ab, ao;
    logic [2:0]   r0s, r1s, as_;

    logic         f_r0v, f_r0r, f_r1v, f_r1r, f_p0v, f_p0r, f_p1v, f_p1r, f_rz, f_re, f_az, f_bz;
    logic [W-1:0] f_r0a, f_r0b, f_r1a, f_r1b, f_ro, f_aa, f_ab, f_ao;
    logic [2:0]   f_r0s, f_r1s, f_as;
    logic [W-1:0] fc = '0;

    int n_chk = 0, n_fail = 0, cyc = 0, acc0 = 0;

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        case (s)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            default: return '0;
        endcase
    endfunction

    function automatic logic legal_op(input logic [2:0] s);
        return s inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    endfunction

    assign ao = alu_ref(aa, ab, as_);
    assign az = (ao == '0);
    always @(posedge clk) fc <= fc + 1;
    assign f_ao = fc;
    assign f_az = fc[0];

    alu_share_arbiter #(.WIDTH(W), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(r0v), .req0_ready_o(r0r), .req0_a_i(r0a), .req0_b_i(r0b), .req0_s_i(r0s),
        .req1_valid_i(r1v), .req1_ready_o(r1r), .req1_a_i(r1a), .req1_b_i(r1b), .req1_s_i(r1s),
        .rsp0_valid_o(p0v), .rsp0_ready_i(p0r), .rsp1_valid_o(p1v), .rsp1_ready_i(p1r),
        .rsp_o_o(ro), .rsp_zero_o(rz), .rsp_err_o(re),
        .alu_a_o(aa), .alu_b_o(ab), .alu_s_o(as_), .alu_o_i(ao), .alu_zero_i(az), .busy_o(bz)
    );

    alu_share_arbiter #(.WIDTH(W), .ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(f_r0v), .req0_ready_o(f_r0r), .req0_a_i(f_r0a), .req0_b_i(f_r0b), .req0_s_i(f_r0s),
        .req1_valid_i(f_r1v), .req1_ready_o(f_r1r), .req1_a_i(f_r1a), .req1_b_i(f_r1b), .req1_s_i(f_r1s),
        .rsp0_valid_o(f_p0v), .rsp0_ready_i(f_p0r), .rsp1_valid_o(f_p1v), .rsp1_ready_i(f_p1r),
        .rsp_o_o(f_ro), .rsp_zero_o(f_rz), .rsp_err_o(f_re),
        .alu_a_o(f_aa), .alu_b_o(f_ab), .alu_s_o(f_as), .alu_o_i(f_ao), .alu_zero_i(f_az), .busy_o(f_bz)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation in flight, response due at a fixed cycle after acceptance
    logic         m_pend, m_last, m_own, m_zero, m_err;
    logic [W-1:0] m_res, m_a, m_b;
    logic [2:0]   m_s;
    int           m_rc;

    always @(negedge clk) begin : cmp
        logic e0, e1, inr, hs;
        logic [W-1:0] sa, sb;
        logic [2:0] ss;
        cyc++;
        if (!rst_n) begin
            m_pend = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_s = '0;
            check("rst req0_ready", W'(r0r), 0);
            check("rst req1_ready", W'(r1r), 0);
            check("rst rsp0_valid", W'(p0v), 0);
            check("rst rsp1_valid", W'(p1v), 0);
            check("rst rsp_o", ro, 0);
            check("rst rsp_zero", W'(rz), 0);
            check("rst rsp_err", W'(re), 0);
            check("rst alu_a", aa, 0);
            check("rst alu_b", ab, 0);
            check("rst alu_s", W'(as_), 0);
            check("rst busy", W'(bz), 0);
        end else begin
            e0  = !m_pend && r0v && (!r1v || m_last);
            e1  = !m_pend && r1v && (!r0v || !m_last);
            inr = m_pend && cyc >= m_rc;
            check("req0_ready", W'(r0r), W'(e0));
            check("req1_ready", W'(r1r), W'(e1));
            check("rsp0_valid", W'(p0v), W'(inr && !m_own));
            check("rsp1_valid", W'(p1v), W'(inr && m_own));
            check("busy", W'(bz), W'(m_pend));
            check("alu_a", aa, m_a);
            check("alu_b", ab, m_b);
            check("alu_s", W'(as_), W'(m_s));
            if (inr) begin
                check("rsp_o", ro, m_res);
                check("rsp_zero", W'(rz), W'(m_zero));
                check("rsp_err", W'(re), W'(m_err));
            end
            if (r0r) acc0++;
            hs = inr && (m_own ? p1r : p0r);
            if (e0 || e1) begin
                sa = e1 ? r1a : r0a; sb = e1 ? r1b : r0b; ss = e1 ? r1s : r0s;
                m_pend = 1'b1; m_own = e1;
                if (legal_op(ss)) begin
                    m_a = sa; m_b = sb; m_s = ss;
                    m_res = alu_ref(sa, sb, ss); m_zero = (m_res == '0); m_err = 1'b0;
                    m_rc = cyc + 2;
                end else begin
                    m_res = '0; m_zero = 1'b0; m_err = 1'b1;
                    m_rc = cyc + 1;
                end
            end else if (hs) begin
                m_pend = 1'b0; m_last = m_own;
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        if (r) begin r1v = v; r1a = a; r1b = b; r1s = s; end
        else begin r0v = v; r0a = a; r0b = b; r0s = s; end
    endtask

    task automatic wait_ready(input logic r, input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(r ? r1r : r0r) && n < 20);
        check(name, W'(r ? r1r : r0r), 1);
    endtask

    task automatic wait_rsp(input logic r, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!(r ? p1v : p0v) && n < 20);
        check("rsp wait", W'(r ? p1v : p0v), 1);
    endtask

    task automatic do_op(input logic r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                         input logic [W-1:0] eo, input logic ez, input logic ee, input int elat);
        int n;
        @(posedge clk); #1;
        drive(r, 1'b1, a, b, s);
        wait_ready(r, "grant");
        @(posedge clk); #1;
        if (r) r1v = 1'b0; else r0v = 1'b0;
        wait_rsp(r, n);
        check("latency", W'(n), W'(elat));
        check("lit rsp_o", ro, eo);
        check("lit rsp_zero", W'(rz), W'(ez));
        check("lit rsp_err", W'(re), W'(ee));
    endtask

    initial begin
        int n, a0;
        logic g;
        logic [W-1:0] snap;
        logic snapz;
        rst_n = 1'b0;
        r0v = 0; r0a = '0; r0b = '0; r0s = '0; r1v = 0; r1a = '0; r1b = '0; r1s = '0;
        p0r = 1; p1r = 1;
        f_r0v = 0; f_r0a = '0; f_r0b = '0; f_r0s = '0; f_r1v = 0; f_r1a = '0; f_r1b = '0; f_r1s = '0;
        f_p0r = 1; f_p1r = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(1'b0, 10, 12, 3'b010, 22, 1'b0, 1'b0, 2);
        do_op(1'b1, 5, 5, 3'b110, 0, 1'b1, 1'b0, 2);
        do_op(1'b1, 10, 11, 3'b111, 1, 1'b0, 1'b0, 2);

        // both requesters held valid from reset: strict alternation starting with 0
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1'b0, 1'b1, 10, 11, 3'b000);
        drive(1'b1, 1'b1, 10, 11, 3'b001);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(r0r || r1r) && n < 20);
            g = r1r;
            check("alt grant", W'(g), W'(k % 2));
            n = 0;
            do begin @(negedge clk); n++; end while (!(p0v || p1v) && n < 20);
            check("alt owner", W'(p1v), W'(k % 2));
            check("alt rsp_o", ro, (k % 2) ? 11 : 10);
        end
        @(posedge clk); #1 r0v = 0; r1v = 0;

        // illegal opcode: error response next cycle, ALU operands untouched
        do_op(1'b0, 3, 4, 3'b100, 0, 1'b0, 1'b1, 1);
        check("illegal alu_s kept", W'(as_), 1);
        check("illegal alu_a kept", aa, 10);

        // response backpressure while the other requester waits
        @(posedge clk); #1 p0r = 0;
        drive(1'b0, 1'b1, 1, 2, 3'b010);
        wait_ready(1'b0, "bp grant");
        @(posedge clk); #1 r0v = 0;
        drive(1'b1, 1'b1, 6, 3, 3'b000);
        wait_rsp(1'b0, n);
        for (int i = 0; i < 5; i++) begin
            check("bp rsp0_valid", W'(p0v), 1);
            check("bp rsp_o", ro, 3);
            check("bp req1_ready", W'(r1r), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 p0r = 1;
        @(negedge clk);
        check("bp hs req1_ready", W'(r1r), 0);
        @(negedge clk);
        check("bp after req1_ready", W'(r1r), 1);
        @(posedge clk); #1 r1v = 0;
        wait_rsp(1'b1, n);
        check("bp rsp1 rsp_o", ro, 2);

        // ALU_LAT=4 instance: operands held 4 cycles, result sampled in the last
        @(posedge clk); #1 f_r0v = 1; f_r0a = 7; f_r0b = 9; f_r0s = 3'b010;
        n = 0;
        do begin @(negedge clk); n++; end while (!f_r0r && n < 20);
        check("lat4 grant", W'(f_r0r), 1);
        @(posedge clk); #1 f_r0v = 0;
        snap = '0; snapz = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("lat4 alu_a", f_aa, 7);
            check("lat4 alu_b", f_ab, 9);
            check("lat4 alu_s", W'(f_as), 2);
            check("lat4 rsp0_valid early", W'(f_p0v), 0);
            snap = f_ao; snapz = f_az;
        end
        @(negedge clk);
        check("lat4 rsp0_valid", W'(f_p0v), 1);
        check("lat4 rsp_o", f_ro, snap);
        check("lat4 rsp_zero", W'(f_rz), W'(snapz));
        check("lat4 rsp_err", W'(f_re), 0);

        // reset in EXEC abandons the op; requester re-issues and is accepted once
        @(posedge clk); #1 drive(1'b0, 1'b1, 20, 22, 3'b010);
        wait_ready(1'b0, "rst grant");
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("rst imm busy", W'(bz), 0);
        check("rst imm alu_a", aa, 0);
        check("rst imm alu_s", W'(as_), 0);
        check("rst imm req0_ready", W'(r0r), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        a0 = acc0;
        wait_ready(1'b0, "reissue grant");
        @(posedge clk); #1 r0v = 0;
        wait_rsp(1'b0, n);
        check("reissue rsp_o", ro, 42);
        repeat (5) @(posedge clk);
        #1 check("reissue accept count", W'(acc0 - a0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
